led_scheduler: RTL and testbench



---
 rtl/led_scheduler_if.sv | 13 +
 rtl/led_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_led_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/led_scheduler_if.sv
// led_scheduler_if: requester/LED bus between on-chip requesters and the LED scheduler
interface led_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   REQ;
    logic [2*NREQ-1:0] MODE;
    logic [NREQ-1:0]   GRANT;
    logic              LED;
    logic              USBPU;

    modport master (output REQ, MODE, input GRANT, LED, USBPU);
    modport slave (input REQ, MODE, output GRANT, LED, USBPU);
endinterface

// File: rtl/led_scheduler.sv
// led_scheduler: round-robin sharing of the single user LED with a minimum time
// slice per owner, a dark gap between owners and per-requester blink modes.
// Build macro PIN1_OVERRIDE_EN adds a PIN_1 button input (active-low, synchronised)
// that forces the LED on while pressed without touching arbitration.
module led_scheduler #(
    parameter int NREQ        = 4,
    parameter int TICK_DIV    = 16000,
    parameter int SLICE_TICKS = 1000,
    parameter int GAP_TICKS   = 200,
    parameter int SLOW_HALF   = 500,
    parameter int FAST_HALF   = 100
) (
    input  logic CLK,
    input  logic RST_N,
`ifdef PIN1_OVERRIDE_EN
    input  logic PIN_1,
`endif
    led_scheduler_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SLICE_TICKS > 0) ? $clog2(SLICE_TICKS + 1) : 1;
    localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int LW = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;
    localparam int FW = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   own_q, own_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [SW-1:0]   slice_q, slice_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [LW-1:0]   slow_cnt_q, slow_cnt_d;
    logic [FW-1:0]   fast_cnt_q, fast_cnt_d;
    logic            slow_on_q, slow_on_d;
    logic            fast_on_q, fast_on_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            led_q, led_d;
`ifdef PIN1_OVERRIDE_EN
    logic            pin_meta_q, pin_meta_d;
    logic            pin_sync_q, pin_sync_d;
`endif

    logic            tick;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic            enter;
    logic            own_req;
    logic            contender;
    logic            leave;
    logic [1:0]      mode_sel;
    logic            blink_on;

    // Free-running prescaler; tick pulses on the last count of each period.
    always_comb begin
        tick  = pre_q == PW'(TICK_DIV - 1);
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    // Round-robin search from ptr; the requester nearest to ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr_q) + k) % NREQ);
            if (bus.REQ[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Ownership FSM with slice, gap and blink-phase counters.
    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        ptr_d      = ptr_q;
        slice_d    = slice_q;
        gap_d      = gap_q;
        slow_cnt_d = slow_cnt_q;
        slow_on_d  = slow_on_q;
        fast_cnt_d = fast_cnt_q;
        fast_on_d  = fast_on_q;
        enter      = 1'b0;
        own_req    = bus.REQ[own_q];
        contender  = |(bus.REQ & ~(NREQ'(1) << own_q));
        leave      = !own_req || (slice_q == SW'(SLICE_TICKS) && contender);
        if (state_q == S_IDLE) begin
            enter = pick_vld;
        end else if (state_q == S_OWN) begin
            if (tick) begin
                slice_d    = (slice_q == SW'(SLICE_TICKS)) ? slice_q : slice_q + 1'b1;
                slow_cnt_d = (slow_cnt_q == LW'(SLOW_HALF - 1)) ? '0 : slow_cnt_q + 1'b1;
                slow_on_d  = slow_on_q ^ (slow_cnt_q == LW'(SLOW_HALF - 1));
                fast_cnt_d = (fast_cnt_q == FW'(FAST_HALF - 1)) ? '0 : fast_cnt_q + 1'b1;
                fast_on_d  = fast_on_q ^ (fast_cnt_q == FW'(FAST_HALF - 1));
            end
            if (leave) begin
                state_d = S_GAP;
                gap_d   = '0;
                ptr_d   = (own_q == IW'(NREQ - 1)) ? '0 : own_q + 1'b1;
            end
        end else begin
            gap_d = (tick && gap_q != GW'(GAP_TICKS)) ? gap_q + 1'b1 : gap_q;
            if (gap_q == GW'(GAP_TICKS)) begin
                state_d = S_IDLE;
                enter   = pick_vld;
            end
        end
        if (enter) begin
            state_d    = S_OWN;
            own_d      = pick_idx;
            slice_d    = '0;
            slow_cnt_d = '0;
            slow_on_d  = 1'b1;
            fast_cnt_d = '0;
            fast_on_d  = 1'b1;
        end
    end

    // GRANT and LED are registered from the next owner and its live mode.
    always_comb begin
        grant_d  = (state_d == S_OWN) ? NREQ'(1) << own_d : '0;
        mode_sel = bus.MODE[{own_d, 1'b0} +: 2];
        blink_on = (mode_sel == 2'b00) ? 1'b1 :
                   (mode_sel == 2'b01) ? slow_on_d :
                   (mode_sel == 2'b10) ? fast_on_d : 1'b0;
        led_d    = (state_d == S_OWN) && blink_on;
`ifdef PIN1_OVERRIDE_EN
        pin_meta_d = PIN_1;
        pin_sync_d = pin_meta_q;
        led_d      = led_d || !pin_sync_q;
`endif
    end

    // State registers; RST_N low clears everything immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            own_q      <= '0;
            ptr_q      <= '0;
            pre_q      <= '0;
            slice_q    <= '0;
            gap_q      <= '0;
            slow_cnt_q <= '0;
            slow_on_q  <= 1'b0;
            fast_cnt_q <= '0;
            fast_on_q  <= 1'b0;
            grant_q    <= '0;
            led_q      <= 1'b0;
`ifdef PIN1_OVERRIDE_EN
            pin_meta_q <= 1'b1;
            pin_sync_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            ptr_q      <= ptr_d;
            pre_q      <= pre_d;
            slice_q    <= slice_d;
            gap_q      <= gap_d;
            slow_cnt_q <= slow_cnt_d;
            slow_on_q  <= slow_on_d;
            fast_cnt_q <= fast_cnt_d;
            fast_on_q  <= fast_on_d;
            grant_q    <= grant_d;
            led_q      <= led_d;
`ifdef PIN1_OVERRIDE_EN
            pin_meta_q <= pin_meta_d;
            pin_sync_q <= pin_sync_d;
`endif
        end
    end

    assign bus.GRANT = grant_q;
    assign bus.LED   = led_q;
    assign bus.USBPU = 1'b0;
endmodule

// File: tb/tb_led_scheduler.sv
// tb_led_scheduler: directed checks of arbitration, gaps, blink modes and reset
module tb_led_scheduler;
    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
`ifdef PIN1_OVERRIDE_EN
    logic PIN_1 = 1'b1;
`endif
    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    led_scheduler_if #(.NREQ(4)) bus ();

    led_scheduler #(
        .NREQ(4), .TICK_DIV(4), .SLICE_TICKS(8), .GAP_TICKS(2), .SLOW_HALF(4), .FAST_HALF(1)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
`ifdef PIN1_OVERRIDE_EN
        .PIN_1(PIN_1),
`endif
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // Advance n clocks; sampling point is 1 ns after each rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            cyc_n++;
        end
    endtask

    // Advance to the sample point after edge p counted from reset release.
    task automatic wait_to(input int p);
        step(p - cyc_n);
    endtask

    task automatic do_reset(input logic [3:0] req, input logic [7:0] mode);
        RST_N    = 1'b0;
        bus.REQ  = req;
        bus.MODE = mode;
        step(2);
        RST_N = 1'b1;
        cyc_n = 0;
    endtask

    task automatic test_reset();
        RST_N    = 1'b0;
        bus.REQ  = 4'b1111;
        bus.MODE = 8'h00;
        step(3);
        total++; if (bus.GRANT !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", bus.GRANT); end
        total++; if (bus.LED !== 1'b0) begin bad++; $display("FAIL reset_led got=%b want=0", bus.LED); end
        total++; if (bus.USBPU !== 1'b0) begin bad++; $display("FAIL reset_usbpu got=%b want=0", bus.USBPU); end
        RST_N = 1'b1;
        cyc_n = 0;
        step(1);
        total++; if (bus.GRANT !== 4'b0001) begin bad++; $display("FAIL release_grant got=%b want=0001", bus.GRANT); end
        total++; if (bus.LED !== 1'b1) begin bad++; $display("FAIL release_led got=%b want=1", bus.LED); end
    endtask

    // Continues from test_reset: owners rotate every 40 cycles (32 own + 8 gap).
    task automatic test_contention();
        logic [3:0] want;
        for (int k = 0; k < 5; k++) begin
            want = 4'b0001 << (k % 4);
            wait_to(1 + 40 * k);
            total++; if (bus.GRANT !== want || bus.LED !== 1'b1) begin bad++; $display("FAIL rr_start%0d got=%b/%b want=%b/1", k, bus.GRANT, bus.LED, want); end
            wait_to(32 + 40 * k);
            total++; if (bus.GRANT !== want || bus.LED !== 1'b1) begin bad++; $display("FAIL rr_end%0d got=%b/%b want=%b/1", k, bus.GRANT, bus.LED, want); end
            if (k < 4) begin
                wait_to(33 + 40 * k);
                total++; if (bus.GRANT !== 4'b0000 || bus.LED !== 1'b0) begin bad++; $display("FAIL gap_start%0d got=%b/%b want=0000/0", k, bus.GRANT, bus.LED); end
                wait_to(40 + 40 * k);
                total++; if (bus.GRANT !== 4'b0000 || bus.LED !== 1'b0) begin bad++; $display("FAIL gap_end%0d got=%b/%b want=0000/0", k, bus.GRANT, bus.LED); end
            end
        end
    endtask

    task automatic test_single();
        do_reset(4'b0100, 8'h00);
        for (int c = 1; c <= 200; c++) begin
            wait_to(c);
            total++; if (bus.GRANT !== 4'b0100 || bus.LED !== 1'b1) begin bad++; $display("FAIL single_c%0d got=%b/%b want=0100/1", c, bus.GRANT, bus.LED); end
        end
    endtask

    task automatic test_blink();
        int   at [13];
        logic ev [13];
        at = '{1, 15, 16, 31, 32, 47, 48, 51, 52, 55, 56, 59, 60};
        ev = '{1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0};
        do_reset(4'b0001, 8'b0000_0001);
        for (int i = 0; i < 13; i++) begin
            if (i == 7) begin
                wait_to(50);
                bus.MODE = 8'b0000_0010;
            end
            wait_to(at[i]);
            total++; if (bus.LED !== ev[i]) begin bad++; $display("FAIL blink_c%0d got=%b want=%b", at[i], bus.LED, ev[i]); end
        end
        bus.MODE = 8'b0000_0011;
        wait_to(61);
        total++; if (bus.LED !== 1'b0 || bus.GRANT !== 4'b0001) begin bad++; $display("FAIL dark_mode got=%b/%b want=0001/0", bus.GRANT, bus.LED); end
    endtask

    task automatic test_drop();
        do_reset(4'b1010, 8'h00);
        wait_to(12);
        total++; if (bus.GRANT !== 4'b0010) begin bad++; $display("FAIL drop_before got=%b want=0010", bus.GRANT); end
        bus.REQ = 4'b1000;
        wait_to(13);
        total++; if (bus.GRANT !== 4'b0000 || bus.LED !== 1'b0) begin bad++; $display("FAIL drop_next got=%b/%b want=0000/0", bus.GRANT, bus.LED); end
        wait_to(20);
        total++; if (bus.GRANT !== 4'b0000 || bus.LED !== 1'b0) begin bad++; $display("FAIL drop_gap got=%b/%b want=0000/0", bus.GRANT, bus.LED); end
        wait_to(21);
        total++; if (bus.GRANT !== 4'b1000 || bus.LED !== 1'b1) begin bad++; $display("FAIL drop_new got=%b/%b want=1000/1", bus.GRANT, bus.LED); end
    endtask

    task automatic test_reset_mid();
        do_reset(4'b1111, 8'h00);
        wait_to(81);
        total++; if (bus.GRANT !== 4'b0100) begin bad++; $display("FAIL mid_owner got=%b want=0100", bus.GRANT); end
        wait_to(90);
        RST_N = 1'b0;
        #1;
        total++; if (bus.GRANT !== 4'b0000 || bus.LED !== 1'b0) begin bad++; $display("FAIL mid_async got=%b/%b want=0000/0", bus.GRANT, bus.LED); end
        step(1);
        RST_N = 1'b1;
        cyc_n = 0;
        step(1);
        total++; if (bus.GRANT !== 4'b0001) begin bad++; $display("FAIL mid_ptr got=%b want=0001", bus.GRANT); end
    endtask

`ifdef PIN1_OVERRIDE_EN
    task automatic test_pin1();
        do_reset(4'b0000, 8'h00);
        step(3);
        PIN_1 = 1'b0;
        step(2);
        total++; if (bus.LED !== 1'b0) begin bad++; $display("FAIL pin_early got=%b want=0", bus.LED); end
        step(1);
        total++; if (bus.LED !== 1'b1 || bus.GRANT !== 4'b0000) begin bad++; $display("FAIL pin_led got=%b/%b want=0000/1", bus.GRANT, bus.LED); end
        PIN_1 = 1'b1;
    endtask
`endif

    initial begin
        bus.REQ  = 4'b0000;
        bus.MODE = 8'h00;
        test_reset();
        test_contention();
        test_single();
        test_blink();
        test_drop();
        test_reset_mid();
`ifdef PIN1_OVERRIDE_EN
        test_pin1();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
